lfsr_msg_encryptor: RTL and testbench
=====================================

# lfsr_msg_encryptor

Hardware stage that feeds the decrypt/depad program. It reads a plaintext ASCII string from a source memory, pre-pads it with `pre_length` blank characters, and post-pads it to 64 bytes. Each byte is offset by −0x20, XORed with a 7-bit LFSR stream, and given an even-parity MSB. The resulting 64-byte ciphertext is written into the encrypted-message region of data memory, where the decrypt/depad processor program consumes it.

## Interface
Parameters:
- `MSG_BYTES`, 64: ciphertext length written per run.
- `MAX_STR`, 52: maximum plaintext characters honoured.
- `MIN_PRE`, 10: minimum leading pad length.

Ports:
- `Clk` in 1: the single clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `Start` in 1: launch request, sampled on the rising edge.
- `pre_length` in 4: leading pad bytes.
- `str_len` in 6: plaintext length in characters.
- `lfsr_ptrn` in 7: feedback tap mask.
- `lfsr_init` in 7: LFSR seed.
- `src_addr` out 6: plaintext read address.
- `src_data` in 8: plaintext byte, valid the cycle after `src_addr` is driven.
- `wr_en` out 1: ciphertext write strobe.
- `wr_addr` out 6: ciphertext byte index 0..63. The system adds the +64 DM base.
- `wr_data` out 8: ciphertext byte.
- `Ack` out 1: run complete (level).

## Operation
- States are IDLE, FETCH, WRITE, DONE.
- **IDLE/DONE with Start=1:** latch the configuration and clear `Ack`.
  - Clamp `pre_length` to `P = max(pre_length, 10)`.
  - Clamp `str_len` to `L = min(str_len, 52)`.
  - Seed with `S = (lfsr_init == 0) ? 7'h01 : lfsr_init`.
  - Set the byte index `i = 0` and go to the per-byte decision.
- **Per-byte decision for byte i:**
  - If `P <= i < P+L`, go to FETCH.
  - Otherwise go to WRITE with `plain = 8'h00`.
- **FETCH (1 cycle):** drive `src_addr = i − P`, then go to WRITE with `plain = src_data − 8'h20` (mod 256).
- **WRITE (1 cycle):**
  - Drive `wr_en = 1` and `wr_addr = i`.
  - Drive `wr_data[6:0] = plain[6:0] ^ lfsr` and `wr_data[7] = ^wr_data[6:0]`.
  - Advance `lfsr <= {lfsr[5:0], ^(lfsr & ptrn)}` and `i <= i+1`.
  - If `i == 63`, go to DONE; otherwise take the next decision.
- **DONE:** `Ack = 1`, held until a new Start or reset.
- Start is ignored while in FETCH or WRITE.
- Input config changes mid-run have no effect; only latched values are used.
- Plaintext bytes beyond the 7-bit range still encrypt on the low 7 bits only. Bit 7 is always the parity bit.
- An all-zero `lfsr_ptrn` is not rejected. The LFSR then shifts in zeros, and the encryption stays well-defined.

## Timing
- **Reset (Reset=0 at an edge):**
  - State returns to IDLE.
  - `Ack=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `src_addr=0`.
  - Reset takes effect mid-run; no further writes are issued.
- `wr_en`, `wr_addr`, `wr_data` and `src_addr` are registered state decodes. The memory commits at the edge ending the WRITE cycle.
- **Latency:**
  - A pad byte takes 1 cycle; a message byte takes 2 cycles.
  - With Start sampled at edge 0, writes occupy cycles 1..64+L.
  - `Ack` rises at edge 65+L (65 with L=0, 117 with L=52).
- Exactly 64 writes per run, in ascending `wr_addr` order, with no gaps or repeats.
- Start held high through DONE re-launches a run one cycle after DONE is entered. `Ack` is high for exactly that one cycle.

## Test plan
- **All-pad run:** `pre_length=10`, `str_len=0`, `ptrn=7'h60`, `init=7'h01`.
  - Required: bytes 0..6 = 0x81, 0x82, 0x84, 0x88, 0x90, 0xA0, 0x41; byte 7 = 0x03.
  - `Ack` rises 65 cycles after Start.
- **Single character:** `pre_length=10`, `str_len=1`, `src[0]=0x41` ("A"), `ptrn=7'h60`, `init=7'h01`.
  - Required: byte 10 = 0x39 (plain 0x21 ^ LFSR 0x18, parity 0).
  - Exactly one FETCH at `src_addr=0`.
  - `Ack` at 66 cycles.
- **Clamping:** `pre_length=3`, `str_len=60`, `init=0`.
  - Required: the run behaves identically to `pre_length=10`, `str_len=52`, `init=7'h01`.
  - Source addresses 0..51 are each read once.
  - `Ack` at 117 cycles.
- **Golden model sweep:** each of the nine tap patterns (0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B), random nonzero seed, string "  f       A joke is a very serious thing."
  - Required: all 64 bytes match the software model, including parity.
- **Reset mid-run:** drive Reset=0 at the 20th write cycle.
  - Required: `wr_en` drops the next cycle and `Ack` stays 0.
  - A subsequent Start produces a full correct 64-byte run.
- **Start handling:** assert Start during a run, then after `Ack`.
  - Required: no effect mid-run.
  - After `Ack`, the new run starts with `Ack` cleared and uses the new config.

Source files
------------

// File: rtl/lfsr_msg_encryptor.sv
// lfsr_msg_encryptor: reads a plaintext string, pads it into 64 byte slots,
// offsets each byte by -0x20, XORs it with a 7-bit LFSR stream and adds an
// even-parity MSB, writing the ciphertext out one byte per write cycle.
module lfsr_msg_encryptor #(
  parameter int MSG_BYTES = 64,
  parameter int MAX_STR   = 52,
  parameter int MIN_PRE   = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] pre_length,
  input  logic [5:0] str_len,
  input  logic [6:0] lfsr_ptrn,
  input  logic [6:0] lfsr_init,
  output logic [5:0] src_addr,
  input  logic [7:0] src_data,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       Ack
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t     state;
  logic       launch;
  logic [5:0] idx;
  logic [6:0] lfsr;
  logic [6:0] ptrn;
  logic [6:0] pad_len;
  logic [6:0] msg_end;

  logic [6:0] cfg_pre;
  logic [6:0] cfg_len;
  logic [6:0] cfg_end;
  logic [6:0] cfg_seed;
  logic [6:0] lfsr_step;
  logic [6:0] dec_pos;
  logic [6:0] dec_key;
  logic       dec_fetch;
  logic [7:0] plain_byte;
  logic [7:0] pad_cipher;
  logic [7:0] msg_cipher;
  logic       unused_plain_msb;

  // Only the low 7 bits carry data; bit 7 of the ciphertext is even parity.
  function automatic logic [7:0] encrypt(input logic [6:0] plain, input logic [6:0] key);
    logic [6:0] body;
    body = plain ^ key;
    return {^body, body};
  endfunction

  // Clamp the launch configuration and precompute the next-slot decision and cipher bytes.
  always_comb begin
    cfg_pre          = ({3'b000, pre_length} < 7'(MIN_PRE)) ? 7'(MIN_PRE) : {3'b000, pre_length};
    cfg_len          = ({1'b0, str_len} > 7'(MAX_STR)) ? 7'(MAX_STR) : {1'b0, str_len};
    cfg_end          = cfg_pre + cfg_len;
    cfg_seed         = (lfsr_init == 7'h00) ? 7'h01 : lfsr_init;
    lfsr_step        = {lfsr[5:0], ^(lfsr & ptrn)};
    dec_pos          = (state == WRITE) ? ({1'b0, idx} + 7'd1) : 7'd0;
    dec_key          = (state == WRITE) ? lfsr_step : lfsr;
    dec_fetch        = (dec_pos >= pad_len) && (dec_pos < msg_end);
    plain_byte       = src_data - 8'h20;
    unused_plain_msb = plain_byte[7];
    pad_cipher       = encrypt(7'h00, dec_key);
    msg_cipher       = encrypt(plain_byte[6:0], lfsr);
  end

  // Single FSM process: one settle cycle after launch, then walk all slots with registered outputs.
  // src_addr runs one fetch ahead so a read is stable before its FETCH cycle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      launch   <= 1'b0;
      idx      <= '0;
      lfsr     <= 7'h01;
      ptrn     <= '0;
      pad_len  <= '0;
      msg_end  <= '0;
      src_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      Ack      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            launch <= 1'b0;
            if (dec_fetch) begin
              state <= FETCH;
            end else begin
              state   <= WRITE;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= pad_cipher;
            end
          end else if (Start) begin
            state    <= IDLE;
            launch   <= 1'b1;
            Ack      <= 1'b0;
            ptrn     <= lfsr_ptrn;
            pad_len  <= cfg_pre;
            msg_end  <= cfg_end;
            lfsr     <= cfg_seed;
            idx      <= '0;
            src_addr <= '0;
          end
        end
        FETCH: begin
          state    <= WRITE;
          wr_en    <= 1'b1;
          wr_addr  <= idx;
          wr_data  <= msg_cipher;
          src_addr <= src_addr + 6'd1;
        end
        WRITE: begin
          lfsr <= lfsr_step;
          idx  <= idx + 6'd1;
          if (idx == 6'(MSG_BYTES - 1)) begin
            state <= DONE;
            wr_en <= 1'b0;
            Ack   <= 1'b1;
          end else if (dec_fetch) begin
            state <= FETCH;
            wr_en <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= dec_pos[5:0];
            wr_data <= pad_cipher;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_msg_encryptor.sv
// tb_lfsr_msg_encryptor: randomized scenarios checked against a byte-level
// reference model of the pad / offset / LFSR-XOR / parity rules.
module tb_lfsr_msg_encryptor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] pre_length = '0;
  logic [5:0] str_len = '0;
  logic [6:0] lfsr_ptrn = '0;
  logic [6:0] lfsr_init = '0;
  logic [5:0] src_addr;
  logic [7:0] src_data;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       Ack;

  logic [7:0] mem [64];
  logic [7:0] exp_data [64];
  int         exp_len;

  logic [5:0] cap_addr [64];
  logic [7:0] cap_data [64];
  int         cap_n;
  int         cap_ack;
  logic       cap_ack0;
  int         cap_fetch [$];

  int vectors = 0;
  int miscompares = 0;

  lfsr_msg_encryptor dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .pre_length(pre_length), .str_len(str_len),
    .lfsr_ptrn(lfsr_ptrn), .lfsr_init(lfsr_init), .src_addr(src_addr), .src_data(src_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .Ack(Ack)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Plaintext source memory with combinational read.
  assign src_data = mem[src_addr];

  task automatic random_mem();
    for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
  endtask

  // Reference ciphertext computed directly from the clamping and encryption rules.
  task automatic model_run(input int pre, input int len, input int ptrn, input int init);
    int p, l, lf, plain, c;
    p = (pre < 10) ? 10 : pre;
    l = (len > 52) ? 52 : len;
    lf = (init == 0) ? 1 : init;
    exp_len = l;
    for (int i = 0; i < 64; i++) begin
      plain = (i >= p && i < p + l) ? ((int'(mem[i - p]) - 32) & 255) : 0;
      c = (plain ^ lf) & 127;
      exp_data[i] = 8'(c | (($countones(c) & 1) << 7));
      lf = ((lf << 1) | ($countones(lf & ptrn) & 1)) & 127;
    end
  endtask

  // Launch one run and record writes, fetch addresses and the Ack cycle (Start edge = cycle 0).
  task automatic run_capture(input int mid_start);
    cap_n = 0;
    cap_ack = -1;
    cap_fetch.delete();
    for (int i = 0; i < 64; i++) begin
      cap_addr[i] = 'x;
      cap_data[i] = 'x;
    end
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cap_ack0 = Ack;
    for (int c = 1; c <= 300 && cap_ack < 0; c++) begin
      @(negedge Clk);
      Start = (c == mid_start);
      if (c == mid_start) begin
        pre_length = 4'($urandom);
        str_len = 6'($urandom);
        lfsr_ptrn = 7'($urandom);
        lfsr_init = 7'($urandom);
      end
      if (wr_en) begin
        if (cap_n < 64) begin
          cap_addr[cap_n] = wr_addr;
          cap_data[cap_n] = wr_data;
        end
        cap_n++;
      end else if (Ack) begin
        cap_ack = c;
      end else begin
        cap_fetch.push_back(int'(src_addr));
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    Start = 1'b0;
    vectors++;
    if (wr_en !== 1'b0 || Ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got wr_en=%b Ack=%b, expected 0 0", wr_en, Ack);
    end
    vectors++;
    if (wr_addr !== 6'd0 || wr_data !== 8'd0 || src_addr !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_busses: got wr_addr=%0d wr_data=%h src_addr=%0d, expected 0 0 0",
               wr_addr, wr_data, src_addr);
    end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    vectors++;
    if (wr_en !== 1'b0 || Ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got wr_en=%b Ack=%b, expected 0 0", wr_en, Ack);
    end
  endtask

  task automatic test_all_pad();
    logic [7:0] golden [8];
    golden = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41, 8'h03};
    random_mem();
    pre_length = 4'd10; str_len = 6'd0; lfsr_ptrn = 7'h60; lfsr_init = 7'h01;
    model_run(10, 0, 'h60, 1);
    run_capture(0);
    vectors++;
    if (cap_n !== 64) begin
      miscompares++;
      $display("[TB] FAIL pad_count: got %0d writes, expected 64", cap_n);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (cap_data[i] !== golden[i]) begin
        miscompares++;
        $display("[TB] FAIL pad_golden%0d: got %h, expected %h", i, cap_data[i], golden[i]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (cap_addr[i] !== 6'(i) || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL pad_byte%0d: got addr %0d data %h, expected addr %0d data %h",
                 i, cap_addr[i], cap_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (cap_ack !== 65) begin
      miscompares++;
      $display("[TB] FAIL pad_ack: got cycle %0d, expected 65", cap_ack);
    end
  endtask

  task automatic test_single_char();
    random_mem();
    mem[0] = 8'h41;
    pre_length = 4'd10; str_len = 6'd1; lfsr_ptrn = 7'h60; lfsr_init = 7'h01;
    model_run(10, 1, 'h60, 1);
    run_capture(0);
    vectors++;
    if (cap_data[10] !== 8'h39) begin
      miscompares++;
      $display("[TB] FAIL char_byte10: got %h, expected 39", cap_data[10]);
    end
    vectors++;
    if (cap_fetch.size() !== 1 || (cap_fetch.size() > 0 && cap_fetch[0] !== 0)) begin
      miscompares++;
      $display("[TB] FAIL char_fetch: got %0d fetches (first %0d), expected 1 at 0",
               cap_fetch.size(), (cap_fetch.size() > 0) ? cap_fetch[0] : -1);
    end
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (cap_addr[i] !== 6'(i) || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL char_byte%0d: got addr %0d data %h, expected addr %0d data %h",
                 i, cap_addr[i], cap_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (cap_ack !== 66) begin
      miscompares++;
      $display("[TB] FAIL char_ack: got cycle %0d, expected 66", cap_ack);
    end
  endtask

  task automatic test_clamping();
    int ptrn;
    random_mem();
    ptrn = $urandom_range(1, 127);
    pre_length = 4'd3; str_len = 6'd60; lfsr_ptrn = 7'(ptrn); lfsr_init = 7'h00;
    model_run(10, 52, ptrn, 1);
    run_capture(0);
    vectors++;
    if (cap_n !== 64) begin
      miscompares++;
      $display("[TB] FAIL clamp_count: got %0d writes, expected 64", cap_n);
    end
    vectors++;
    if (cap_fetch.size() !== 52) begin
      miscompares++;
      $display("[TB] FAIL clamp_fetches: got %0d, expected 52", cap_fetch.size());
    end
    for (int k = 0; k < cap_fetch.size() && k < 52; k++) begin
      vectors++;
      if (cap_fetch[k] !== k) begin
        miscompares++;
        $display("[TB] FAIL clamp_src%0d: got %0d, expected %0d", k, cap_fetch[k], k);
      end
    end
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (cap_addr[i] !== 6'(i) || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL clamp_byte%0d: got addr %0d data %h, expected addr %0d data %h",
                 i, cap_addr[i], cap_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (cap_ack !== 117) begin
      miscompares++;
      $display("[TB] FAIL clamp_ack: got cycle %0d, expected 117", cap_ack);
    end
  endtask

  task automatic test_golden_sweep();
    int    pats [9];
    string s;
    int    pre, init;
    pats = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};
    s = "  f       A joke is a very serious thing.";
    for (int t = 0; t < 9; t++) begin
      random_mem();
      for (int k = 0; k < s.len(); k++) mem[k] = s[k];
      pre = $urandom_range(0, 15);
      init = $urandom_range(1, 127);
      pre_length = 4'(pre); str_len = 6'(s.len()); lfsr_ptrn = 7'(pats[t]); lfsr_init = 7'(init);
      model_run(pre, s.len(), pats[t], init);
      run_capture(0);
      vectors++;
      if (cap_n !== 64) begin
        miscompares++;
        $display("[TB] FAIL sweep%0d_count: got %0d writes, expected 64", t, cap_n);
      end
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (cap_addr[i] !== 6'(i) || cap_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("[TB] FAIL sweep%0d_byte%0d: got addr %0d data %h, expected addr %0d data %h",
                   t, i, cap_addr[i], cap_data[i], i, exp_data[i]);
        end
      end
      vectors++;
      if (cap_ack !== 65 + exp_len) begin
        miscompares++;
        $display("[TB] FAIL sweep%0d_ack: got cycle %0d, expected %0d", t, cap_ack, 65 + exp_len);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int  pre, len, ptrn, init, n;
    logic hit, stray;
    random_mem();
    pre = $urandom_range(0, 15); len = $urandom_range(0, 52);
    ptrn = $urandom_range(0, 127); init = $urandom_range(0, 127);
    pre_length = 4'(pre); str_len = 6'(len); lfsr_ptrn = 7'(ptrn); lfsr_init = 7'(init);
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    hit = 1'b0;
    for (int c = 1; c <= 200 && !hit; c++) begin
      @(negedge Clk);
      if (wr_en) n++;
      if (n == 20) begin
        hit = 1'b1;
        Reset = 1'b0;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("[TB] FAIL rst_reach20: got %0d writes, expected 20", n);
    end
    @(negedge Clk);
    Reset = 1'b1;
    vectors++;
    if (wr_en !== 1'b0 || Ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_drop: got wr_en=%b Ack=%b, expected 0 0", wr_en, Ack);
    end
    stray = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (wr_en !== 1'b0 || Ack !== 1'b0) stray = 1'b1;
    end
    vectors++;
    if (stray) begin
      miscompares++;
      $display("[TB] FAIL rst_quiet: got activity after reset, expected none");
    end
    model_run(pre, len, ptrn, init);
    run_capture(0);
    vectors++;
    if (cap_n !== 64) begin
      miscompares++;
      $display("[TB] FAIL rst_rerun_count: got %0d writes, expected 64", cap_n);
    end
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (cap_addr[i] !== 6'(i) || cap_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("[TB] FAIL rst_rerun_byte%0d: got addr %0d data %h, expected addr %0d data %h",
                 i, cap_addr[i], cap_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (cap_ack !== 65 + exp_len) begin
      miscompares++;
      $display("[TB] FAIL rst_rerun_ack: got cycle %0d, expected %0d", cap_ack, 65 + exp_len);
    end
  endtask

  task automatic test_start_handling();
    int pre, len, ptrn, init;
    for (int r = 0; r < 2; r++) begin
      random_mem();
      pre = $urandom_range(0, 15); len = $urandom_range(0, 63);
      ptrn = $urandom_range(0, 127); init = $urandom_range(0, 127);
      pre_length = 4'(pre); str_len = 6'(len); lfsr_ptrn = 7'(ptrn); lfsr_init = 7'(init);
      model_run(pre, len, ptrn, init);
      run_capture((r == 0) ? 30 : 0);
      vectors++;
      if (cap_ack0 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL start%0d_ackclr: got Ack=%b, expected 0", r, cap_ack0);
      end
      vectors++;
      if (cap_n !== 64) begin
        miscompares++;
        $display("[TB] FAIL start%0d_count: got %0d writes, expected 64", r, cap_n);
      end
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (cap_addr[i] !== 6'(i) || cap_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("[TB] FAIL start%0d_byte%0d: got addr %0d data %h, expected addr %0d data %h",
                   r, i, cap_addr[i], cap_data[i], i, exp_data[i]);
        end
      end
      vectors++;
      if (cap_ack !== 65 + exp_len) begin
        miscompares++;
        $display("[TB] FAIL start%0d_ack: got cycle %0d, expected %0d", r, cap_ack, 65 + exp_len);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   pre, len, ptrn, init;
    int   first_ack, second_ack;
    logic prev_ack, ack_after, wen_after;
    logic [5:0] addr_after;
    logic [7:0] data_after;
    random_mem();
    pre = $urandom_range(0, 15); len = $urandom_range(0, 20);
    ptrn = $urandom_range(0, 127); init = $urandom_range(0, 127);
    pre_length = 4'(pre); str_len = 6'(len); lfsr_ptrn = 7'(ptrn); lfsr_init = 7'(init);
    model_run(pre, len, ptrn, init);
    first_ack = -1; second_ack = -1; prev_ack = 1'b0;
    ack_after = 1'bx; wen_after = 1'bx; addr_after = 'x; data_after = 'x;
    @(negedge Clk);
    Start = 1'b1;
    for (int c = 0; c <= 400 && second_ack < 0; c++) begin
      @(negedge Clk);
      if (Ack && !prev_ack) begin
        if (first_ack < 0) first_ack = c;
        else second_ack = c;
      end
      if (first_ack >= 0 && c == first_ack + 1) ack_after = Ack;
      if (first_ack >= 0 && c == first_ack + 2) begin
        wen_after = wr_en; addr_after = wr_addr; data_after = wr_data;
        Start = 1'b0;
      end
      prev_ack = Ack;
    end
    Start = 1'b0;
    vectors++;
    if (first_ack !== 65 + exp_len) begin
      miscompares++;
      $display("[TB] FAIL b2b_ack1: got cycle %0d, expected %0d", first_ack, 65 + exp_len);
    end
    vectors++;
    if (ack_after !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_ackpulse: got Ack=%b one cycle later, expected 0", ack_after);
    end
    vectors++;
    if (wen_after !== 1'b1 || addr_after !== 6'd0 || data_after !== exp_data[0]) begin
      miscompares++;
      $display("[TB] FAIL b2b_relaunch: got wr_en=%b addr %0d data %h, expected 1 0 %h",
               wen_after, addr_after, data_after, exp_data[0]);
    end
    vectors++;
    if (second_ack !== 131 + 2 * exp_len) begin
      miscompares++;
      $display("[TB] FAIL b2b_ack2: got cycle %0d, expected %0d", second_ack, 131 + 2 * exp_len);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 8'h00;
    test_reset();
    test_all_pad();
    test_single_char();
    test_clamping();
    test_golden_sweep();
    test_reset_mid_run();
    test_start_handling();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
